// File: rtl/present_cipher_core_if.sv
// Handshake and data bundle for present_cipher_core.
// The requester drives key, block and control inputs; the core returns ready, result and valid.
interface present_cipher_core_if #(
    parameter int KEY_WIDTH = 80
);
    logic [KEY_WIDTH-1:0] key_i;
    logic                 key_load_i;
    logic [63:0]          data_i;
    logic                 mode_i;
    logic                 start_i;
    logic                 ready_o;
    logic [63:0]          data_o;
    logic                 valid_o;

    modport master (
        output key_i, key_load_i, data_i, mode_i, start_i,
        input  ready_o, data_o, valid_o
    );

    modport slave (
        input  key_i, key_load_i, data_i, mode_i, start_i,
        output ready_o, data_o, valid_o
    );
endinterface

// File: rtl/present_cipher_core.sv
// PRESENT block cipher, 80/128-bit key, one round per clock on a shared round datapath.
// The key is expanded once per load; master key and final round key are cached for both directions.
module present_cipher_core #(
    parameter int KEY_WIDTH = 80
) (
    input logic                clk_i,
    input logic                rst_i,
    present_cipher_core_if.slave bus
);
    localparam int KW   = KEY_WIDTH;
    localparam int CPOS = (KW == 128) ? 62 : 15;
    localparam logic [63:0] SBOX     = 64'h21748FE3DA09B65C;
    localparam logic [63:0] SBOX_INV = 64'hA970364BD21C8FE5;

    if (KEY_WIDTH != 80 && KEY_WIDTH != 128) begin : g_bad_key_width
        $error("present_cipher_core: KEY_WIDTH must be 80 or 128");
    end

    typedef enum logic [1:0] {IDLE, KEXP, RUN, FIN} fsm_e;

    function automatic logic [3:0] s_nib(input logic [3:0] n, input logic inv);
        return inv ? SBOX_INV[{n, 2'b00} +: 4] : SBOX[{n, 2'b00} +: 4];
    endfunction

    function automatic logic [63:0] s_layer(input logic [63:0] x, input logic inv);
        logic [63:0] r;
        r = x;
        for (int i = 0; i < 16; i++) r[4*i +: 4] = s_nib(x[4*i +: 4], inv);
        return r;
    endfunction

    // Bit i travels to 16*i mod 63; bit 63 stays put.
    function automatic logic [63:0] p_layer(input logic [63:0] x, input logic inv);
        logic [63:0] r;
        r = x;
        for (int i = 0; i < 63; i++) begin
            if (inv) r[i] = x[(16*i) % 63];
            else     r[(16*i) % 63] = x[i];
        end
        return r;
    endfunction

    function automatic logic [KW-1:0] key_upd(input logic [KW-1:0] k, input logic [4:0] c);
        logic [KW-1:0] r;
        r = {k[KW-62:0], k[KW-1:KW-61]};
        r[KW-1 -: 4] = s_nib(r[KW-1 -: 4], 1'b0);
        if (KW == 128) r[KW-5 -: 4] = s_nib(r[KW-5 -: 4], 1'b0);
        r[CPOS +: 5] = r[CPOS +: 5] ^ c;
        return r;
    endfunction

    function automatic logic [KW-1:0] key_inv(input logic [KW-1:0] k, input logic [4:0] c);
        logic [KW-1:0] r;
        r = k;
        r[CPOS +: 5] = r[CPOS +: 5] ^ c;
        r[KW-1 -: 4] = s_nib(r[KW-1 -: 4], 1'b1);
        if (KW == 128) r[KW-5 -: 4] = s_nib(r[KW-5 -: 4], 1'b1);
        return {r[60:0], r[KW-1:61]};
    endfunction

    fsm_e          fsm_q, fsm_d;
    logic [KW-1:0] mkey_q, mkey_d, fkey_q, fkey_d, wkey_q, wkey_d;
    logic [63:0]   blk_q, blk_d, data_q, data_d;
    logic [4:0]    cnt_q, cnt_d;
    logic          mode_q, mode_d, key_valid_q, key_valid_d, valid_q, valid_d;
    logic [KW-1:0] k_fwd, k_bwd;

    always_comb begin
        fsm_d       = fsm_q;
        mkey_d      = mkey_q;
        fkey_d      = fkey_q;
        wkey_d      = wkey_q;
        blk_d       = blk_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        key_valid_d = key_valid_q;
        valid_d     = 1'b0;
        k_fwd       = key_upd(wkey_q, cnt_q);
        k_bwd       = key_inv(wkey_q, cnt_q);
        case (fsm_q)
            IDLE: begin
                // A key load in the same cycle as a block start takes priority and drops the block.
                if (bus.key_load_i) begin
                    mkey_d      = bus.key_i;
                    wkey_d      = bus.key_i;
                    cnt_d       = 5'd1;
                    key_valid_d = 1'b0;
                    fsm_d       = KEXP;
                end else if (bus.start_i && key_valid_q) begin
                    mode_d = bus.mode_i;
                    if (bus.mode_i) begin
                        blk_d  = bus.data_i ^ fkey_q[KW-1 -: 64];
                        wkey_d = fkey_q;
                        cnt_d  = 5'd31;
                    end else begin
                        blk_d  = bus.data_i;
                        wkey_d = mkey_q;
                        cnt_d  = 5'd1;
                    end
                    fsm_d = RUN;
                end
            end
            KEXP: begin
                wkey_d = k_fwd;
                if (cnt_q == 5'd31) begin
                    fkey_d      = k_fwd;
                    key_valid_d = 1'b1;
                    fsm_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            RUN: begin
                if (!mode_q) begin
                    blk_d  = p_layer(s_layer(blk_q ^ wkey_q[KW-1 -: 64], 1'b0), 1'b0);
                    wkey_d = k_fwd;
                    if (cnt_q == 5'd31) fsm_d = FIN;
                    else                cnt_d = cnt_q + 5'd1;
                end else begin
                    blk_d  = s_layer(p_layer(blk_q, 1'b1), 1'b1) ^ k_bwd[KW-1 -: 64];
                    wkey_d = k_bwd;
                    if (cnt_q == 5'd1) fsm_d = FIN;
                    else               cnt_d = cnt_q - 5'd1;
                end
            end
            FIN: begin
                data_d  = mode_q ? blk_q : (blk_q ^ wkey_q[KW-1 -: 64]);
                valid_d = 1'b1;
                fsm_d   = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm_q       <= IDLE;
            mkey_q      <= '0;
            fkey_q      <= '0;
            wkey_q      <= '0;
            blk_q       <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            key_valid_q <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            mkey_q      <= mkey_d;
            fkey_q      <= fkey_d;
            wkey_q      <= wkey_d;
            blk_q       <= blk_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            key_valid_q <= key_valid_d;
            valid_q     <= valid_d;
        end
    end

    assign bus.ready_o = (fsm_q == IDLE) && key_valid_q;
    assign bus.data_o  = data_q;
    assign bus.valid_o = valid_q;
endmodule

// File: doc/present_cipher_core.md
# present_cipher_core

Parametrised PRESENT block-cipher core supporting 80- and 128-bit keys, encryption and decryption, and valid/ready handshaking. Runs one round per clock using a single shared round datapath. Expands the key once per key load and caches both the master key and the final round key, so it can encrypt or decrypt any number of blocks under that key without re-expansion. Replaces the fixed 80-bit, encrypt-only, unhandshaked encryptor in the cipher subsystem.

## Interface
- KEY_WIDTH, 80, key size in bits; legal values are 80 and 128 only. Any other value is an elaboration error.
- clk_i  input  1  clock; all state changes on the rising edge
- rst_i  input  1  reset; asynchronous, active-high
- key_i  input  KEY_WIDTH  master key, sampled when key_load_i is accepted
- key_load_i  input  1  request key load and expansion
- data_i  input  64  plaintext (encrypt) or ciphertext (decrypt)
- mode_i  input  1  0 = encrypt, 1 = decrypt; sampled with start_i
- start_i  input  1  block valid; accepted only when ready_o = 1
- ready_o  output  1  high when IDLE and an expanded key is present
- data_o  output  64  result register; holds its value until the next result
- valid_o  output  1  single-cycle pulse when data_o is updated

## Operation
- Round key RK(k) = k[KEY_WIDTH-1 : KEY_WIDTH-64].
- S is the PRESENT S-box C56B90AD3EF84712; P is the pLayer (bit i moves to 16·i mod 63, bit 63 is fixed). S⁻¹ and P⁻¹ are their inverses.
- Key update U(k, c) for 80-bit keys, in order:
  - rotate left by 61
  - apply S to [79:76]
  - XOR c[4:0] into [19:15]
- Key update U(k, c) for 128-bit keys, in order:
  - rotate left by 61
  - apply S to [127:124] and to [123:120]
  - XOR c into [66:62]
- U⁻¹(k, c) undoes the update: XOR c, then S⁻¹ on the same nibbles, then rotate right by 61.
- Registers: mkey (master key), fkey (K32), wkey (working key), state[63:0], cnt[4:0], mode_r, key_valid.
- FSM states: IDLE, KEXP, RUN, FIN.
- IDLE:
  - key_load_i = 1: mkey ← key_i, wkey ← key_i, cnt ← 1, key_valid ← 0, go to KEXP.
  - else start_i & ready_o, encrypt: state ← data_i, wkey ← mkey, cnt ← 1, go to RUN.
  - else start_i & ready_o, decrypt: state ← data_i ^ RK(fkey), wkey ← fkey, cnt ← 31, go to RUN.
- KEXP: each cycle wkey ← U(wkey, cnt) and cnt ← cnt+1. In the cycle with cnt = 31: fkey ← U(wkey, 31), key_valid ← 1, go to IDLE.
- RUN, encrypt: state ← P(S(state ^ RK(wkey))), wkey ← U(wkey, cnt), cnt ← cnt+1. After the cnt = 31 cycle, go to FIN.
- RUN, decrypt: k' = U⁻¹(wkey, cnt); state ← S⁻¹(P⁻¹(state)) ^ RK(k'); wkey ← k'; cnt ← cnt−1. After the cnt = 1 cycle, go to FIN.
- FIN:
  - encrypt: data_o ← state ^ RK(wkey)
  - decrypt: data_o ← state
  - in both modes: valid_o ← 1 for one cycle, go to IDLE
- ready_o = (FSM == IDLE) & key_valid. It is registered or decoded directly from registers; it never depends combinationally on inputs.
- Boundary and conflict rules:
  - key_load_i and start_i asserted in the same IDLE cycle: the key load wins and the block is dropped.
  - key_load_i outside IDLE is ignored.
  - start_i while ready_o = 0 is ignored.
  - cnt never wraps during operation; the 5-bit counter covers the range 1..31.
  - Reloading the same key still performs a full 31-cycle expansion.

## Timing
- Reset values: ready_o = 0, valid_o = 0, data_o = 0. All other registers reset to 0, key_valid = 0, FSM = IDLE.
- Assertion of rst_i at any time (including mid-KEXP or mid-RUN) aborts the operation immediately. A new key load is required afterwards.
- Key load accepted at edge T: ready_o rises after edge T+31.
- Block accepted at edge E:
  - RUN occupies edges E+1 .. E+31.
  - FIN at edge E+32: data_o is valid and valid_o = 1 for the cycle following E+32.
  - ready_o returns high after edge E+32.
  - Latency is 32 cycles. Maximum throughput is one block per 33 cycles, because the next start_i can be accepted at edge E+33.
- The same latency applies to both modes and both key widths.

## Test plan
- KEY_WIDTH=80, encrypt, after expansion:
  - key 0, pt 0 → data_o = 5579C1387B228445; valid_o pulses exactly 32 cycles after the accept edge.
  - key all-ones, pt all-ones → 3333DCD3213210D2.
- KEY_WIDTH=80, decrypt: key 0, ct 5579C1387B228445 → 0000000000000000. Then, without reloading, encrypt pt all-ones under key 0 → A112FFC72F68417B.
- KEY_WIDTH=128, key 0, pt 0 → 96DB702A2E6900AF. Decrypting that value → 0.
- Handshake and conflicts:
  - start_i held during KEXP and RUN produces no extra results.
  - key_load_i and start_i asserted together in IDLE → 31-cycle expansion follows and valid_o never pulses.
  - start_i before any key load → ignored; ready_o stays 0.
- Reset: assert rst_i at round 15 of an encryption → all outputs are 0 immediately, ready_o stays 0 until a reload. The reload followed by an encryption then reproduces 5579C1387B228445.
